pcie_cfg_scan_ctrl: RTL and testbench

// Root-port config-space scan sequencer, successor to the single-function CfgRd0 sweep.

---
 rtl/pcie_cfg_scan_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pcie_cfg_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cfg_scan_ctrl.sv
// rtl/pcie_cfg_scan_ctrl.sv - Root-port config-space CfgRd0 scan sequencer
module pcie_cfg_scan_ctrl #(
    parameter int          NUM_FUNC    = 1,
    parameter logic [7:0]  BUS_NUM     = 8'd1,
    parameter logic [4:0]  DEV_NUM     = 5'd0,
    parameter logic [9:0]  REG_FIRST   = 10'h00,
    parameter logic [9:0]  REG_LAST    = 10'h28,
    parameter int          TIMEOUT_CYC = 1024,
    parameter int          MAX_RETRY   = 2
) (
    input  logic        user_clk,
    input  logic        user_reset_n,
    input  logic        user_lnk_up,
    input  logic        cfg1_done,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [9:0]  reg_number,
    output logic [15:0] completer_id,
    output logic [3:0]  req_type,
    output logic [10:0] dword_count,
    input  logic        cpl_valid,
    input  logic [2:0]  cpl_status,
    input  logic [31:0] cpl_data,
    output logic        cap_valid,
    output logic [2:0]  cap_func,
    output logic [9:0]  cap_reg,
    output logic [31:0] cap_data,
    output logic [7:0]  func_present,
    output logic        scan_done,
    output logic        scan_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
    localparam int unsigned RW = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [2:0]    FUNC_LAST  = 3'(NUM_FUNC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_CFG1, S_ISSUE, S_WAIT_CPL, S_NEXT, S_NEXT_FUNC, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      func_q, func_d;
    logic [9:0]      reg_q, reg_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            cap_valid_q, cap_valid_d;
    logic [2:0]      cap_func_q, cap_func_d;
    logic [9:0]      cap_reg_q, cap_reg_d;
    logic [31:0]     cap_data_q, cap_data_d;
    logic [7:0]      present_q, present_d;
    logic            err_q, err_d;

    // State and datapath registers
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q     <= S_IDLE;
            func_q      <= 3'd0;
            reg_q       <= REG_FIRST;
            retry_q     <= '0;
            timer_q     <= '0;
            cap_valid_q <= 1'b0;
            cap_func_q  <= 3'd0;
            cap_reg_q   <= 10'd0;
            cap_data_q  <= 32'd0;
            present_q   <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            func_q      <= func_d;
            reg_q       <= reg_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            cap_valid_q <= cap_valid_d;
            cap_func_q  <= cap_func_d;
            cap_reg_q   <= cap_reg_d;
            cap_data_q  <= cap_data_d;
            present_q   <= present_d;
            err_q       <= err_d;
        end
    end

    // Next-state: scan walk, completion decode, timeout/retry, link-drop abort
    always_comb begin
        state_d     = state_q;
        func_d      = func_q;
        reg_d       = reg_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        cap_valid_d = 1'b0;
        cap_func_d  = cap_func_q;
        cap_reg_d   = cap_reg_q;
        cap_data_d  = cap_data_q;
        present_d   = present_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (user_lnk_up) state_d = S_WAIT_CFG1;
            end
            S_WAIT_CFG1: begin
                if (cfg1_done) begin
                    state_d = S_ISSUE;
                    func_d  = 3'd0;
                    reg_d   = REG_FIRST;
                    retry_d = '0;
                end
            end
            S_ISSUE: begin
                if (req_ready) begin
                    state_d = S_WAIT_CPL;
                    timer_d = '0;
                end
            end
            S_WAIT_CPL: begin
                timer_d = timer_q + TW'(1);
                // A completion landing on the timeout cycle takes priority
                if (cpl_valid) begin
                    if (cpl_status == 3'd0) begin
                        cap_valid_d = 1'b1;
                        cap_func_d  = func_q;
                        cap_reg_d   = reg_q;
                        cap_data_d  = cpl_data;
                        if (reg_q == REG_FIRST) present_d[func_q] = 1'b1;
                        state_d = S_NEXT;
                    end else if (cpl_status == 3'd1 && reg_q == REG_FIRST) begin
                        state_d = S_NEXT_FUNC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_NEXT;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (reg_q < REG_LAST) begin
                    reg_d   = reg_q + 10'd1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_NEXT_FUNC;
                end
            end
            S_NEXT_FUNC: begin
                // Retry count also clears here: an absent function may have been retried
                retry_d = '0;
                reg_d   = REG_FIRST;
                if (func_q < FUNC_LAST) begin
                    func_d  = func_q + 3'd1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && !user_lnk_up) begin
            state_d     = S_IDLE;
            func_d      = 3'd0;
            reg_d       = REG_FIRST;
            retry_d     = '0;
            timer_d     = '0;
            cap_valid_d = 1'b0;
            present_d   = 8'd0;
            err_d       = 1'b0;
        end
    end

    // Outputs: descriptor fields are only non-zero while a request is offered
    always_comb begin
        req_valid    = (state_q == S_ISSUE);
        completer_id = req_valid ? {BUS_NUM, DEV_NUM, func_q} : 16'd0;
        req_type     = req_valid ? 4'b1000 : 4'd0;
        dword_count  = req_valid ? 11'd1 : 11'd0;
        reg_number   = reg_q;
        scan_done    = (state_q == S_DONE);
        scan_err     = err_q;
        func_present = present_q;
        cap_valid    = cap_valid_q;
        cap_func     = cap_func_q;
        cap_reg      = cap_reg_q;
        cap_data     = cap_data_q;
    end

endmodule

// File: tb/tb_pcie_cfg_scan_ctrl.sv
// tb/tb_pcie_cfg_scan_ctrl.sv - Scan sequencer bench with transaction-level reference model
module tb_pcie_cfg_scan_ctrl;

    localparam int          NF  = 4;
    localparam int          TO  = 16;
    localparam int          MR  = 2;
    localparam logic [9:0]  RF  = 10'h00;
    localparam logic [9:0]  RL  = 10'h28;
    localparam logic [7:0]  BUS = 8'h3A;
    localparam logic [4:0]  DEV = 5'd7;

    logic        clk = 1'b0, rst_n = 1'b0, lnk = 1'b0, cfg1 = 1'b0;
    logic        req_ready = 1'b0, cpl_valid = 1'b0;
    logic [2:0]  cpl_status = 3'd0;
    logic [31:0] cpl_data = 32'd0;
    logic        req_valid, cap_valid, scan_done, scan_err;
    logic [9:0]  reg_number, cap_reg;
    logic [15:0] completer_id;
    logic [3:0]  req_type;
    logic [10:0] dword_count;
    logic [2:0]  cap_func;
    logic [31:0] cap_data;
    logic [7:0]  func_present;

    pcie_cfg_scan_ctrl #(
        .NUM_FUNC(NF), .BUS_NUM(BUS), .DEV_NUM(DEV), .REG_FIRST(RF),
        .REG_LAST(RL), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)
    ) dut (
        .user_clk(clk), .user_reset_n(rst_n), .user_lnk_up(lnk), .cfg1_done(cfg1),
        .req_valid(req_valid), .req_ready(req_ready), .reg_number(reg_number),
        .completer_id(completer_id), .req_type(req_type), .dword_count(dword_count),
        .cpl_valid(cpl_valid), .cpl_status(cpl_status), .cpl_data(cpl_data),
        .cap_valid(cap_valid), .cap_func(cap_func), .cap_reg(cap_reg), .cap_data(cap_data),
        .func_present(func_present), .scan_done(scan_done), .scan_err(scan_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;

    // Reference model: scan position and expected results
    int         m_func, m_reg, m_retry;
    bit         m_done, m_err, m_active;
    logic [7:0] m_present;
    logic [44:0] cap_q[$];

    int          mode;          // 0 = directed, 1 = random, 2 = random with link drop
    int          cnt;           // cycles until the scheduled completion is sampled
    logic [2:0]  p_status;
    logic [31:0] p_data;
    int          ready_hold;
    int          n_req, n_cap, cyc;
    int          hs_cyc[$];
    bit          drop_armed;
    int          drop_wait;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_func = 0; m_reg = int'(RF); m_retry = 0;
        m_done = 0; m_err = 0; m_present = 8'd0;
        cap_q.delete();
        cnt = 0;
    endtask

    task automatic next_func();
        m_retry = 0;
        m_reg = int'(RF);
        if (m_func < NF - 1) m_func++;
        else m_done = 1;
    endtask

    task automatic advance();
        m_retry = 0;
        if (m_reg < int'(RL)) m_reg++;
        else next_func();
    endtask

    // Decide the completer's answer to the request just accepted and step the model
    task automatic on_request();
        int kind, d, r;
        logic [31:0] data;
        n_req++;
        data = $urandom;
        d = 5;
        kind = 0;
        if (mode == 0) begin
            if (m_func == 1 && m_reg == int'(RF)) kind = 1;
            else if (m_func == 0 && m_reg == 5) begin
                kind = 3;
                hs_cyc.push_back(cyc);
            end else if (m_func == 2 && m_reg == 7) d = TO;
        end else begin
            r = $urandom_range(0, 99);
            if (r < 70)      begin kind = 0; d = $urandom_range(1, TO - 1); end
            else if (r < 76) begin kind = 0; d = TO; end
            else if (r < 84) begin kind = 1; d = $urandom_range(1, TO - 1); end
            else if (r < 88) begin kind = 2; d = $urandom_range(1, TO - 1); end
            else kind = 3;
            if (mode == 2 && !drop_armed && m_reg == 16) begin
                kind = 3;
                drop_armed = 1;
                drop_wait = 4;
            end
        end
        case (kind)
            0: begin
                p_status = 3'd0;
                cap_q.push_back({3'(m_func), 10'(m_reg), data});
                if (m_reg == int'(RF)) m_present[m_func] = 1'b1;
                advance();
            end
            1: begin
                p_status = 3'd1;
                if (m_reg == int'(RF)) next_func();
                else begin m_err = 1; advance(); end
            end
            2: begin
                p_status = 3'($urandom_range(2, 7));
                m_err = 1;
                advance();
            end
            default: begin
                // Late completion one cycle past the timeout; the DUT must ignore it
                p_status = 3'd0;
                d = TO + 1;
                if (m_retry < MR) m_retry++;
                else begin m_err = 1; advance(); end
            end
        endcase
        p_data = data;
        cnt = d;
    endtask

    task automatic cycle();
        bit hs;
        hs = req_valid && req_ready;
        @(posedge clk);
        #1;
        cyc++;
        cpl_valid = 1'b0;
        if (hs) on_request();
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                cpl_valid  = 1'b1;
                cpl_status = p_status;
                cpl_data   = p_data;
            end
        end
        if (ready_hold > 0) begin
            ready_hold--;
            req_ready = 1'b0;
        end else begin
            req_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        end
    endtask

    // Compare process: DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid) begin
                if (!m_active || m_done) check("req_unexpected", 64'(req_valid), 64'd0);
                else begin
                    check("req_reg", 64'(reg_number), 64'(m_reg));
                    check("req_cid", 64'(completer_id), 64'({BUS, DEV, 3'(m_func)}));
                    check("req_type_len", 64'({req_type, dword_count}), 64'({4'b1000, 11'd1}));
                end
            end else begin
                check("req_idle_fields", 64'({completer_id, req_type, dword_count}), 64'd0);
            end
            if (cap_valid) begin
                n_cap++;
                if (cap_q.size() == 0) check("cap_unexpected", 64'(cap_valid), 64'd0);
                else check("cap", 64'({cap_func, cap_reg, cap_data}), 64'(cap_q.pop_front()));
            end
            if (scan_done) check("done_early", 64'(m_done), 64'd1);
        end
    end

    task automatic link_down(input int n);
        lnk = 1'b0;
        m_active = 0;
        cnt = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic link_drop_midscan();
        link_down(3);
        check("drop_req_valid", 64'(req_valid), 64'd0);
        check("drop_flags", 64'({scan_done, scan_err, func_present, cap_valid}), 64'd0);
        check("drop_reg", 64'(reg_number), 64'(RF));
        lnk = 1'b1;
        model_reset();
        m_active = 1;
    endtask

    task automatic run_scan(input int md);
        mode = md;
        drop_armed = 0;
        drop_wait = 0;
        n_req = 0;
        n_cap = 0;
        model_reset();
        lnk = 1'b1;
        cfg1 = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("wait_cfg1_no_req", 64'(req_valid), 64'd0);
        m_active = 1;
        cfg1 = 1'b1;
        ready_hold = 21;
        req_ready = 1'b0;
        cycle();
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("hold_valid", 64'(req_valid), 64'd1);
        end
        check("hold_no_accept", 64'(n_req), 64'd0);
        for (int i = 0; i < 30000; i++) begin
            cycle();
            if (drop_wait > 0) begin
                drop_wait--;
                if (drop_wait == 0) link_drop_midscan();
            end
            if (m_done && cnt == 0 && cap_q.size() == 0 && scan_done) break;
        end
        check("scan_done", 64'(scan_done), 64'd1);
        check("caps_drained", 64'(cap_q.size()), 64'd0);
        check("func_present", 64'(func_present), 64'(m_present));
        check("scan_err", 64'(scan_err), 64'(m_err));
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("done_sticky_no_req", 64'({scan_done, req_valid}), 64'b10);
        end
    endtask

    initial begin
        cyc = 0; ready_hold = 0; mode = 0; m_active = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", 64'({req_valid, cap_valid, scan_done, scan_err, func_present,
                               completer_id, req_type, dword_count}), 64'd0);
        check("rst_reg", 64'(reg_number), 64'(RF));
        rst_n = 1'b1;

        // Directed: func1 absent, reg 5 of func0 silent, func2 reg 7 answered on the timeout cycle
        run_scan(0);
        check("dir_present_lit", 64'(func_present), 64'h0D);
        check("dir_err_lit", 64'(scan_err), 64'd1);
        check("dir_caps_lit", 64'(n_cap), 64'd122);
        check("dir_reqs_lit", 64'(n_req), 64'd126);
        check("dir_retry_count", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() == 3) begin
            check("retry_gap1_ge_to", 64'(hs_cyc[1] - hs_cyc[0] >= TO), 64'd1);
            check("retry_gap2_ge_to", 64'(hs_cyc[2] - hs_cyc[1] >= TO), 64'd1);
        end

        link_down(3);
        check("done_cleared", 64'({scan_done, scan_err, func_present}), 64'd0);

        run_scan(2);
        check("drop_happened", 64'(drop_armed), 64'd1);
        link_down(3);
        run_scan(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
